// File: rtl/lc3b_types.sv
// Shared LC3b types: machine word plus the mult/div opcode and state encodings
// used by the execute-stage iterative multiplier/divider.
package lc3b_types;

    localparam int LC3B_WORD_W = 16;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } mult_div_op;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } mult_div_state;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the shift-add multiplier / restoring divider.
// Multiply: acc holds the running product, quo holds the shifting multiplier.
// Divide: acc[WIDTH:0] holds the partial remainder, quo shifts dividend out and quotient in.
module mult_div_step
    import lc3b_types::*;
#(
    parameter int WIDTH = LC3B_WORD_W
) (
    input  mult_div_op         op,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic [WIDTH-1:0]   quo_in,
    output logic [2*WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0]   quo_out
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = a_in[gi] & quo_in[0];
        end
    endgenerate

    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        shifted = {acc_in[WIDTH-1:0], quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, b_in};
        acc_out = '0;
        quo_out = '0;
        if (op == MD_MUL) begin
            // Carry out of the add lands in the top product bit after the shift.
            acc_out = {sum, acc_in[WIDTH-1:1]};
            quo_out = {1'b0, quo_in[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_out = {{(WIDTH-1){1'b0}}, diff};
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {{(WIDTH-1){1'b0}}, shifted};
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/lc3b_mult_div_unit.sv
// Iterative unsigned multiplier/divider, one bit per cycle. Holds the FSM,
// iteration counter, operand latches and result registers around mult_div_step.
module lc3b_mult_div_unit
    import lc3b_types::*;
#(
    parameter int WIDTH = LC3B_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] aux,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mult_div_state      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mult_div_op         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   aux_q, aux_d;
    logic               dbz_q, dbz_d;

    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   quo_step;
    logic               accept;

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc_in  (acc_q),
        .a_in    (a_q),
        .b_in    (b_q),
        .quo_in  (quo_q),
        .acc_out (acc_step),
        .quo_out (quo_step)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        quo_d      = quo_q;
        dbz_pend_d = dbz_pend_q;
        result_d   = result_q;
        aux_d      = aux_q;
        dbz_d      = dbz_q;
        accept     = start && (state_q != MD_CALC);

        case (state_q)
            MD_IDLE: begin
                if (accept) state_d = MD_CALC;
            end
            MD_CALC: begin
                acc_d = acc_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_DONE;
                    // The flag is published alongside the result it belongs to.
                    dbz_d   = dbz_pend_q;
                    if (op_q == MD_MUL) begin
                        result_d = acc_step[WIDTH-1:0];
                        aux_d    = acc_step[2*WIDTH-1:WIDTH];
                    end else begin
                        result_d = quo_step;
                        aux_d    = acc_step[WIDTH-1:0];
                    end
                end
            end
            MD_DONE: begin
                state_d = accept ? MD_CALC : MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        if (accept) begin
            op_d       = mult_div_op'(op);
            a_d        = a;
            b_d        = b;
            cnt_d      = CNT_W'(WIDTH);
            acc_d      = '0;
            quo_d      = op ? a : b;
            dbz_pend_d = op && (b == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            op_q       <= MD_MUL;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            quo_q      <= '0;
            dbz_pend_q <= 1'b0;
            result_q   <= '0;
            aux_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            quo_q      <= quo_d;
            dbz_pend_q <= dbz_pend_d;
            result_q   <= result_d;
            aux_q      <= aux_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q == MD_CALC);
    assign done        = (state_q == MD_DONE);
    assign result      = result_q;
    assign aux         = aux_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_lc3b_mult_div_unit.sv
// Directed bench for lc3b_mult_div_unit: expected results come from a behavioural
// arithmetic model, queued at start and compared when done pulses.
module tb_lc3b_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] aux;
    logic        div_by_zero;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] aux;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    lc3b_mult_div_unit #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .aux         (aux),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [31:0] p;
        if (!o) begin
            p     = {16'h0, x} * {16'h0, y};
            e.res = p[15:0];
            e.aux = p[31:16];
            e.dbz = 1'b0;
        end else if (y == 16'h0) begin
            e.res = 16'hFFFF;
            e.aux = x;
            e.dbz = 1'b1;
        end else begin
            e.res = x / y;
            e.aux = x % y;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drive a one-cycle start from the current (post-edge) point.
    task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y, input bit push);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare.
    task automatic wait_done(input string tag, input bit check_lat);
        int   lat = 0;
        int   busy_cnt = 0;
        exp_t e;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        if (check_lat) begin
            check({tag, "_latency"}, lat + 1, 17);
            check({tag, "_busy_cycles"}, busy_cnt, 16);
        end
        if (sb_q.size() == 0) begin
            checks++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_result"}, {16'h0, result}, {16'h0, e.res});
            check({tag, "_aux"}, {16'h0, aux}, {16'h0, e.aux});
            check({tag, "_dbz"}, {31'h0, div_by_zero}, {31'h0, e.dbz});
        end
    endtask

    initial begin
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", {16'h0, result}, 32'h0);
        check("rst_aux", {16'h0, aux}, 32'h0);
        check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: 3*5 with latency, then single-cycle done and held outputs
        issue(1'b0, 16'd3, 16'd5, 1'b1);
        check("t1_busy_after_start", {31'h0, busy}, 32'h1);
        wait_done("t1_mul_3x5", 1'b1);
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", {31'h0, done}, 32'h0);
        check("t1_result_held", {16'h0, result}, 32'h000F);

        // 2: multiplies exercising upper half and carry
        issue(1'b0, 16'h1234, 16'h0100, 1'b1);
        wait_done("t2_mul_1234x0100", 1'b0);
        issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("t2_mul_ffffxffff", 1'b1);

        // 3: divides, including dividend smaller than divisor
        issue(1'b1, 16'd100, 16'd7, 1'b1);
        wait_done("t3_div_100_7", 1'b0);
        issue(1'b1, 16'd5, 16'd9, 1'b1);
        wait_done("t3_div_5_9", 1'b0);

        // 4: divide by zero
        issue(1'b1, 16'h0ABC, 16'h0000, 1'b1);
        wait_done("t4_div_by_zero", 1'b1);

        // 5: start while busy is ignored; back-to-back start from DONE
        issue(1'b0, 16'd3, 16'd5, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        issue(1'b1, 16'd9, 16'd3, 1'b0);
        check("t5_busy_during_ignored", {31'h0, busy}, 32'h1);
        wait_done("t5_mul_3x5", 1'b0);
        issue(1'b1, 16'd9, 16'd3, 1'b1);
        check("t5_busy_after_b2b", {31'h0, busy}, 32'h1);
        wait_done("t5_div_9_3", 1'b1);

        // 6: asynchronous reset mid-operation
        issue(1'b1, 16'd100, 16'd7, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_done", {31'h0, done}, 32'h0);
        check("t6_rst_result", {16'h0, result}, 32'h0);
        check("t6_rst_aux", {16'h0, aux}, 32'h0);
        check("t6_rst_dbz", {31'h0, div_by_zero}, 32'h0);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("t6_no_done_after_rst", n_done, 0);
        issue(1'b0, 16'd2, 16'd2, 1'b1);
        wait_done("t6_mul_2x2", 1'b1);

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
